uart_tx_param: RTL and testbench

Parametrised, runtime-configurable UART transmitter. It is the next generation of the team's fixed-format transmitter.
- Runs on the system clock with an internal baud divider instead of being clocked by a baud tick.
- Accepts characters over a valid/ready handshake.
- Supports 5..MAX_DATA_W data bits, five parity modes, 1 or 2 stop bits, LSB/MSB-first order and break generation.
- Sits between a TX FIFO or register interface and the serial pin.

---
 rtl/uart_tx_param.sv | 145 ++++++++++++++
 tb/tb_uart_tx_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Runtime-configurable UART transmitter with an internal baud divider, valid/ready input,
// 5..MAX_DATA_W data bits, five parity modes, 1/2 stop bits, bit order select and break.
module uart_tx_param #(
    parameter int MAX_DATA_W = 9,
    parameter int DIV_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_W-1:0]      baud_div,
    input  logic [3:0]            frame_length,
    input  logic [2:0]            parity_type,
    input  logic                  stop_bits,
    input  logic                  msb_first,
    input  logic                  send_break,
    input  logic                  s_valid,
    input  logic [MAX_DATA_W-1:0] s_data,
    output logic                  s_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t                state, state_next;
    logic [DIV_W-1:0]      cnt, div_lat, div_eff;
    logic [3:0]            bit_idx, len, len_c, ridx;
    logic [MAX_DATA_W-1:0] shreg, load_data;
    logic                  par_bit, par_en, stop2, stop_second, from_break;
    logic                  load_par_bit, load_par_en, par_x;
    logic                  handshake, bit_end;

    assign s_ready   = (state == IDLE) && !send_break;
    assign busy      = (state != IDLE);
    assign handshake = s_valid && s_ready;
    assign bit_end   = (cnt == div_lat);

    // The character is reordered at load time so the datapath always shifts LSB-out;
    // parity is likewise precomputed over only the frame_length transmitted bits.
    always_comb begin
        len_c = (frame_length < 4'd5) ? 4'd5 :
                (frame_length > 4'(MAX_DATA_W)) ? 4'(MAX_DATA_W) : frame_length;
        div_eff   = (baud_div == '0) ? DIV_W'(1) : baud_div;
        load_data = '0;
        par_x     = 1'b0;
        ridx      = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (4'(i) < len_c) begin
                ridx         = len_c - 4'd1 - 4'(i);
                load_data[i] = msb_first ? s_data[ridx] : s_data[i];
                par_x        = par_x ^ s_data[i];
            end
        end
        case (parity_type)
            3'd1:    begin load_par_en = 1'b1; load_par_bit = ~par_x; end
            3'd2:    begin load_par_en = 1'b1; load_par_bit = par_x;  end
            3'd3:    begin load_par_en = 1'b1; load_par_bit = 1'b1;   end
            3'd4:    begin load_par_en = 1'b1; load_par_bit = 1'b0;   end
            default: begin load_par_en = 1'b0; load_par_bit = 1'b0;   end
        endcase
    end

    always_comb begin
        state_next = state;
        tx         = 1'b1;
        case (state)
            IDLE: begin
                if (handshake)       state_next = START;
                else if (send_break) state_next = BREAK;
            end
            START: begin
                tx = 1'b0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                tx = shreg[0];
                if (bit_end && (bit_idx == len - 4'd1))
                    state_next = par_en ? PARITY : STOP;
            end
            PARITY: begin
                tx = par_bit;
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end && (!stop2 || stop_second)) state_next = IDLE;
            end
            BREAK: begin
                tx = 1'b0;
                if (!send_break) state_next = STOP;
            end
            default: state_next = IDLE;
        endcase
    end

    // The baud counter restarts whenever a new bit (or break) begins, so every bit is a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            div_lat     <= '0;
            bit_idx     <= '0;
            len         <= '0;
            par_bit     <= 1'b0;
            par_en      <= 1'b0;
            stop2       <= 1'b0;
            stop_second <= 1'b0;
            from_break  <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            state   <= state_next;
            tx_done <= (state == STOP) && (state_next == IDLE) && !from_break;
            case (state)
                IDLE: begin
                    cnt         <= '0;
                    stop_second <= 1'b0;
                    if (handshake) begin
                        shreg      <= load_data;
                        len        <= len_c;
                        bit_idx    <= '0;
                        par_bit    <= load_par_bit;
                        par_en     <= load_par_en;
                        stop2      <= stop_bits;
                        div_lat    <= div_eff;
                        from_break <= 1'b0;
                    end else if (send_break) begin
                        div_lat    <= div_eff;
                        stop2      <= 1'b1;
                        from_break <= 1'b1;
                    end
                end
                BREAK: cnt <= '0;
                default: begin
                    cnt <= bit_end ? '0 : cnt + DIV_W'(1);
                    if ((state == DATA) && bit_end) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 4'd1;
                    end
                    if ((state == STOP) && bit_end) stop_second <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: table of frame formats with hand-derived line
// sequences fed through a scoreboard, plus back-to-back, reset-abort and break sequences.
module tb_uart_tx_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [3:0]  frame_length;
    logic [2:0]  parity_type;
    logic        stop_bits, msb_first, send_break, s_valid;
    logic [8:0]  s_data;
    logic        s_ready, tx, busy, tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    // bits: line levels after the start bit (data, parity, stops), first-sent at bit n-1
    typedef struct {
        logic [15:0] div;
        logic [3:0]  len;
        logic [2:0]  ptype;
        logic        stop2;
        logic        msb;
        logic [8:0]  data;
        logic [15:0] bits;
        int          n;
    } vec_t;

    typedef struct {
        int          p;
        logic [15:0] bits;
        int          n;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    uart_tx_param #(.MAX_DATA_W(9), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .frame_length(frame_length),
        .parity_type(parity_type), .stop_bits(stop_bits), .msb_first(msb_first),
        .send_break(send_break), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t make_exp(input logic [15:0] div, input logic [15:0] bits, input int n);
        exp_t e;
        e.p    = ((div == 16'd0) ? 1 : int'(div)) + 1;
        e.bits = bits;
        e.n    = n;
        return e;
    endfunction

    // Performs the handshake from an idle negedge and returns at the first start-bit cycle.
    task automatic applyStimulus(input vec_t v);
        baud_div     = v.div;
        frame_length = v.len;
        parity_type  = v.ptype;
        stop_bits    = v.stop2;
        msb_first    = v.msb;
        s_data       = v.data;
        s_valid      = 1'b1;
        #1 compare("s_ready at handshake", s_ready, 1);
        sb.push_back(make_exp(v.div, v.bits, v.n));
        @(negedge clk);
        s_valid      = 1'b0;
        baud_div     = 16'($urandom);
        frame_length = 4'($urandom);
        parity_type  = 3'($urandom);
        stop_bits    = 1'($urandom);
        msb_first    = 1'($urandom);
        s_data       = 9'($urandom);
    endtask

    // Checks one whole frame from its first start-bit cycle; returns at the tx_done cycle.
    task automatic checkOutput();
        exp_t e;
        bit   ok;
        logic b;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard: got empty queue, expected a pending frame");
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k <= e.n; k++) begin
            b  = (k == 0) ? 1'b0 : e.bits[e.n - k];
            ok = 1'b1;
            for (int c = 0; c < e.p; c++) begin
                if (tx !== b || busy !== 1'b1 || tx_done !== 1'b0) ok = 1'b0;
                @(negedge clk);
            end
            compare($sformatf("line bit %0d level %0b held", k, b), {31'b0, ok}, 1);
        end
        compare("tx_done pulse", tx_done, 1);
        compare("tx idle after frame", tx, 1);
        compare("busy after frame", busy, 0);
        compare("s_ready after frame", s_ready, 1);
    endtask

    initial begin
        bit ok;
        bit seen_done, seen_low;

        vecs[0] = '{16'd3, 4'd8,  3'd0, 1'b0, 1'b0, 9'h055, 16'b101010101,    9};
        vecs[1] = '{16'd1, 4'd7,  3'd2, 1'b0, 1'b0, 9'h1C1, 16'b100000101,    9};
        vecs[2] = '{16'd2, 4'd5,  3'd1, 1'b1, 1'b1, 9'h1FC, 16'b11100011,     8};
        vecs[3] = '{16'd0, 4'd3,  3'd3, 1'b0, 1'b0, 9'h01F, 16'b1111111,      7};
        vecs[4] = '{16'd1, 4'd15, 3'd4, 1'b0, 1'b0, 9'h1A5, 16'b10100101101,  11};
        vecs[5] = '{16'd1, 4'd6,  3'd6, 1'b0, 1'b1, 9'h1F2, 16'b1100101,      7};
        vecs[6] = '{16'd1, 4'd8,  3'd1, 1'b0, 1'b0, 9'h100, 16'b0000000011,   10};
        vecs[7] = '{16'd1, 4'd9,  3'd2, 1'b1, 1'b1, 9'h103, 16'b100000011111, 12};

        rst = 1'b1;
        baud_div = 16'd3; frame_length = 4'd8; parity_type = 3'd0;
        stop_bits = 1'b0; msb_first = 1'b0; send_break = 1'b0;
        s_valid = 1'b0; s_data = '0;
        #2;
        compare("reset tx", tx, 1);
        compare("reset busy", busy, 0);
        compare("reset tx_done", tx_done, 0);
        compare("reset s_ready", s_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) ok = 1'b0;
        end
        compare("idle without s_valid", {31'b0, ok}, 1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
            @(negedge clk);
            compare($sformatf("tx_done single cycle vec %0d", i), tx_done, 0);
        end

        // Back-to-back with s_valid held: second start bit directly follows the tx_done cycle.
        baud_div = 16'd3; frame_length = 4'd8; parity_type = 3'd0;
        stop_bits = 1'b0; msb_first = 1'b0;
        s_data = 9'h0A5; s_valid = 1'b1;
        sb.push_back(make_exp(16'd3, 16'b101001011, 9));
        sb.push_back(make_exp(16'd3, 16'b001111001, 9));
        @(negedge clk);
        s_data = 9'h03C;
        checkOutput();
        @(negedge clk);
        s_valid = 1'b0;
        checkOutput();
        @(negedge clk);

        // Reset during DATA abandons the frame.
        baud_div = 16'd3; frame_length = 4'd8; parity_type = 3'd0;
        stop_bits = 1'b0; msb_first = 1'b0; s_data = 9'h055; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (8) @(negedge clk);
        compare("mid-frame busy", busy, 1);
        compare("mid-frame data bit1 low", tx, 0);
        rst = 1'b1;
        #1;
        compare("async reset tx", tx, 1);
        compare("async reset busy", busy, 0);
        compare("async reset tx_done", tx_done, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 compare("s_ready after reset release", s_ready, 1);
        seen_done = 1'b0;
        seen_low  = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx_done === 1'b1) seen_done = 1'b1;
            if (tx !== 1'b1) seen_low = 1'b1;
        end
        compare("no tx_done after abort", {31'b0, seen_done}, 0);
        compare("line idle after abort", {31'b0, seen_low}, 0);

        // Break: 50 cycles requested, then two stop bits of 4 cycles each, no tx_done.
        baud_div = 16'd3;
        send_break = 1'b1;
        #1 compare("s_ready with break request", s_ready, 0);
        ok = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (tx !== 1'b0 || s_ready !== 1'b0 || tx_done !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            if (k == 50) send_break = 1'b0;
        end
        compare("break holds line low 50 cycles", {31'b0, ok}, 1);
        ok = 1'b1;
        for (int k = 51; k <= 58; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || s_ready !== 1'b0 || tx_done !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        compare("break stop bits 8 cycles", {31'b0, ok}, 1);
        @(negedge clk);
        compare("break end busy", busy, 0);
        compare("break end no tx_done", tx_done, 0);
        compare("break end s_ready", s_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
